// File: rtl/pio_key_in.sv
// Avalon-MM input PIO for pushbutton/switch lines.
// Each input bit is synchronized, debounced and edge-detected; detected edges
// are latched in a write-1-to-clear capture register that drives a maskable
// level interrupt. Reads are zero-wait-state and side-effect free.
module pio_key_in #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] clr;
    logic             wr_mask;
    logic             wr_clr;

    // Upper writedata bits are not backed by any register when WIDTH < 32.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_mask = chipselect & ~write_n & (address == 2'd2);
    assign wr_clr  = chipselect & ~write_n & (address == 2'd3);
    assign clr     = wr_clr ? writedata[WIDTH-1:0] : '0;

    // Two-flop synchronizer followed by a per-bit stability counter; a bit
    // only moves to its new level after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Edge selection on the debounced data.
    always_comb begin
        rise = stable & ~prev;
        fall = ~stable & prev;
        case (EDGE_TYPE)
            0:       ev = rise;
            1:       ev = fall;
            default: ev = rise | fall;
        endcase
    end

    // Previous-value register, edge capture (set beats clear) and irq mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev     <= '0;
            edge_cap <= '0;
            irq_mask <= '0;
        end else begin
            prev     <= stable;
            edge_cap <= ev | (edge_cap & ~clr);
            if (wr_mask) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edge_cap & irq_mask);

    // Combinational read mux; independent of chipselect.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = stable;
            2'd2:    readdata[WIDTH-1:0] = irq_mask;
            2'd3:    readdata[WIDTH-1:0] = edge_cap;
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_pio_key_in.sv
// Self-checking bench for pio_key_in (WIDTH=4, DEBOUNCE_CYCLES=4, falling edges).
// Inputs change 1 time unit after a rising edge; outputs are sampled a few
// time units later, well before the next rising edge.
module tb_pio_key_in;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    pio_key_in #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .EDGE_TYPE       (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          is_irq;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        logic [1:0]  wa;
        logic [31:0] wd;
        logic [1:0]  ra;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[6];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic compare_front();
        sb_t         s;
        logic [31:0] got;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: got empty queue, required an expected entry");
        end else begin
            s   = sb.pop_front();
            got = s.is_irq ? {31'b0, irq} : readdata;
            if (got !== s.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h required 0x%0h", s.name, got, s.exp);
            end
        end
    endtask

    task automatic expect_reg(input string nm, input logic [1:0] a, input logic [31:0] e);
        sb_t s;
        s.name   = nm;
        s.is_irq = 1'b0;
        s.exp    = e;
        address  = a;
        sb.push_back(s);
        #1;
        compare_front();
    endtask

    task automatic expect_irq(input string nm, input logic e);
        sb_t s;
        s.name   = nm;
        s.is_irq = 1'b1;
        s.exp    = {31'b0, e};
        sb.push_back(s);
        #1;
        compare_front();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{wa: 2'd2, wd: 32'hFFFF_FFF5, ra: 2'd2, exp_rd: 32'h5, exp_irq: 1'b0};
        tbl[1] = '{wa: 2'd2, wd: 32'h0000_000A, ra: 2'd2, exp_rd: 32'hA, exp_irq: 1'b0};
        tbl[2] = '{wa: 2'd0, wd: 32'h0000_0000, ra: 2'd0, exp_rd: 32'hF, exp_irq: 1'b0};
        tbl[3] = '{wa: 2'd1, wd: 32'h0000_000F, ra: 2'd1, exp_rd: 32'h0, exp_irq: 1'b0};
        tbl[4] = '{wa: 2'd3, wd: 32'h0000_000F, ra: 2'd3, exp_rd: 32'h0, exp_irq: 1'b0};
        tbl[5] = '{wa: 2'd2, wd: 32'h0000_0000, ra: 2'd2, exp_rd: 32'h0, exp_irq: 1'b0};

        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;

        // Reset state
        step(1);
        expect_reg("rst_data", 2'd0, 32'h0);
        expect_reg("rst_mask", 2'd2, 32'h0);
        expect_reg("rst_cap",  2'd3, 32'h0);
        expect_irq("rst_irq",  1'b0);
        reset = 1'b0;

        // Released keys settle high; the rising transition is not captured
        step(20);
        expect_reg("idle_data", 2'd0, 32'hF);
        expect_reg("idle_cap",  2'd3, 32'h0);
        expect_irq("idle_irq",  1'b0);

        // Register map vectors
        for (int i = 0; i < 6; i++) begin
            wr(tbl[i].wa, tbl[i].wd);
            expect_reg($sformatf("tbl%0d_rd", i), tbl[i].ra, tbl[i].exp_rd);
            expect_irq($sformatf("tbl%0d_irq", i), tbl[i].exp_irq);
        end

        // Write without chipselect is ignored
        chipselect = 1'b0;
        write_n    = 1'b0;
        address    = 2'd2;
        writedata  = 32'hF;
        step(1);
        write_n    = 1'b1;
        writedata  = '0;
        expect_reg("nocs_mask", 2'd2, 32'h0);

        // Bit 0 press: exact debounce latency, capture one edge later
        wr(2'd2, 32'h1);
        in_port[0] = 1'b0;
        step(5);
        expect_reg("lat_before", 2'd0, 32'hF);
        step(1);
        expect_reg("lat_stable", 2'd0, 32'hE);
        expect_reg("lat_cap0",   2'd3, 32'h0);
        expect_irq("lat_irq0",   1'b0);
        step(1);
        expect_reg("lat_cap1",   2'd3, 32'h1);
        expect_irq("lat_irq1",   1'b1);
        wr(2'd3, 32'h1);
        expect_reg("clr_cap",    2'd3, 32'h0);
        expect_irq("clr_irq",    1'b0);

        // Bit 1 glitch of 3 cycles is rejected
        in_port[1] = 1'b0;
        step(3);
        in_port[1] = 1'b1;
        step(12);
        expect_reg("glitch_data", 2'd0, 32'hE);
        expect_reg("glitch_cap",  2'd3, 32'h0);
        expect_irq("glitch_irq",  1'b0);

        // Bit 1 low for 4 cycles is accepted (unmasked bit, no irq)
        in_port[1] = 1'b0;
        step(4);
        in_port[1] = 1'b1;
        step(12);
        expect_reg("pulse4_cap",  2'd3, 32'h2);
        expect_reg("pulse4_data", 2'd0, 32'hE);
        expect_irq("pulse4_irq",  1'b0);

        // Build edge_cap = 0x3, then clear bit 0
        in_port[0] = 1'b1;
        step(10);
        in_port[0] = 1'b0;
        step(10);
        expect_reg("cap3",      2'd3, 32'h3);
        expect_irq("cap3_irq",  1'b1);
        wr(2'd3, 32'h1);
        expect_reg("cap3_clr1", 2'd3, 32'h2);
        expect_irq("cap2_irq",  1'b0);

        // Clear of bit 1 coincides with a new bit-1 falling event: set wins
        in_port[1] = 1'b0;
        step(6);
        expect_reg("coinc_data", 2'd0, 32'hC);
        wr(2'd3, 32'h2);
        expect_reg("coinc_cap",  2'd3, 32'h2);
        step(1);
        expect_reg("coinc_hold", 2'd3, 32'h2);
        in_port[1] = 1'b1;
        step(12);
        wr(2'd3, 32'hF);
        expect_reg("clr_all",    2'd3, 32'h0);

        // Mask gating of a captured bit 2 event
        wr(2'd2, 32'h0);
        in_port[2] = 1'b0;
        step(10);
        expect_reg("m_cap",     2'd3, 32'h4);
        expect_irq("m_irq_off", 1'b0);
        wr(2'd2, 32'h4);
        expect_irq("m_irq_on",  1'b1);
        wr(2'd2, 32'h0);
        expect_irq("m_irq_cut", 1'b0);
        expect_reg("m_cap_kept", 2'd3, 32'h4);

        // Reset mid-debounce (bit-2 counter at 2) with irq high
        wr(2'd2, 32'h4);
        expect_irq("pre_rst_irq", 1'b1);
        in_port[2] = 1'b1;
        step(4);
        reset      = 1'b1;
        in_port[2] = 1'b0;
        step(1);
        expect_irq("mid_rst_irq",  1'b0);
        expect_reg("mid_rst_data", 2'd0, 32'h0);
        expect_reg("mid_rst_mask", 2'd2, 32'h0);
        expect_reg("mid_rst_cap",  2'd3, 32'h0);
        reset = 1'b0;
        step(20);
        expect_reg("post_rst_data", 2'd0, 32'hA);
        expect_reg("post_rst_cap",  2'd3, 32'h0);
        expect_irq("post_rst_irq",  1'b0);
        wr(2'd2, 32'hF);
        expect_reg("post_rst_mask", 2'd2, 32'hF);
        expect_irq("post_rst_irq2", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
